// File: rtl/dm_store_ram_pkg.sv
// Shared M-stage instruction class codes and decode helpers for the data memory
// and the load-extension stage.
package dm_store_ram_pkg;

    localparam int TYPE_W = 6;
    localparam int NUM_LANES = 4;

    localparam logic [TYPE_W-1:0] T_LW = 6'b000110;
    localparam logic [TYPE_W-1:0] T_LH = 6'b010001;
    localparam logic [TYPE_W-1:0] T_LB = 6'b010010;
    localparam logic [TYPE_W-1:0] T_SW = 6'b000111;
    localparam logic [TYPE_W-1:0] T_SH = 6'b010011;
    localparam logic [TYPE_W-1:0] T_SB = 6'b010100;

    typedef struct packed {
        logic [NUM_LANES-1:0] be;
        logic [31:0]          word;
        logic                 align_err;
    } lane_req_t;

    function automatic logic is_store(input logic [TYPE_W-1:0] t);
        return (t == T_SW) || (t == T_SH) || (t == T_SB);
    endfunction

endpackage

// File: rtl/dm_byte_en.sv
// Maps instruction class and low address bits to byte enables, the lane-placed
// write word and the misalignment flag. Purely combinational.
module dm_byte_en
    import dm_store_ram_pkg::*;
(
    input  logic [TYPE_W-1:0] type_code,
    input  logic [1:0]        addr_lo,
    input  logic [31:0]       wdata,
    output lane_req_t         req
);

    always_comb begin
        req.be        = '0;
        req.word      = wdata;
        req.align_err = 1'b0;
        // Data is replicated across lanes; the enables pick which lanes land.
        case (type_code)
            T_SW: req.be = 4'b1111;
            T_SH: begin
                req.be   = addr_lo[1] ? 4'b1100 : 4'b0011;
                req.word = {2{wdata[15:0]}};
            end
            T_SB: begin
                req.be   = 4'b0001 << addr_lo;
                req.word = {4{wdata[7:0]}};
            end
            default: ;
        endcase
        case (type_code)
            T_LW, T_SW: req.align_err = (addr_lo != 2'b00);
            T_LH, T_SH: req.align_err = addr_lo[0];
            default:    req.align_err = 1'b0;
        endcase
    end

endmodule

// File: rtl/dm_store_ram.sv
// Word-organised data memory with byte-lane stores, combinational read,
// alignment/range checking and a committed-store counter.
module dm_store_ram
    import dm_store_ram_pkg::*;
#(
    parameter int          DEPTH = 3072,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [TYPE_W-1:0] type_code,
    input  logic              we,
    output logic [31:0]       rdata,
    output logic              align_err,
    output logic              range_err,
    output logic [31:0]       store_cnt
);

    localparam int          IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    logic [31:0]   offset;
    logic [IW-1:0] idx;
    lane_req_t     req;
    logic          commit;
    logic [31:0]   mem [DEPTH];

    // Addresses below BASE wrap to a huge offset and fall out of range.
    assign offset    = addr - BASE;
    assign idx       = offset[IW+1:2];
    assign range_err = ({1'b0, offset} >= SPAN);

    dm_byte_en u_byte_en (
        .type_code (type_code),
        .addr_lo   (addr[1:0]),
        .wdata     (wdata),
        .req       (req)
    );

    assign align_err = req.align_err;
    assign commit    = we && is_store(type_code) && !req.align_err && !range_err;

    assign rdata = (!reset || range_err) ? 32'h0 : mem[idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            for (int l = 0; l < NUM_LANES; l++)
                if (req.be[l]) mem[idx][8*l +: 8] <= req.word[8*l +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      store_cnt <= '0;
        else if (commit) store_cnt <= store_cnt + 32'd1;
    end

endmodule
